// File: rtl/inst_fetcher_pkg.sv
// Shared widths, defaults and types for the instruction fetch front end.
package inst_fetcher_pkg;

  localparam int unsigned InstAddrBus = 32;
  localparam int unsigned InstBus     = 32;
  localparam int unsigned ByteBus     = 8;

  localparam logic Enable  = 1'b1;
  localparam logic Disable = 1'b0;

  localparam logic [InstAddrBus-1:0] ResetPcDefault = 32'h0;

  typedef enum logic {
    StFetch,
    StHold
  } fetch_state_e;

endpackage

// File: rtl/inst_queue.sv
// Synchronous FIFO of {pc, inst} entries; flush wins over push and pop.
module inst_queue
  import inst_fetcher_pkg::*;
#(
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned EntW = InstAddrBus + InstBus
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic            flush,
  input  logic [EntW-1:0] wdata,
  output logic [EntW-1:0] rdata,
  output logic            full,
  output logic            empty,
  output logic [PtrW:0]   count
);

  localparam logic [PtrW:0] PtrOne = 1;

  logic [EntW-1:0] mem [Depth];
  logic [PtrW:0]   wr_ptr_q, rd_ptr_q;
  logic            do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                 (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr_q[PtrW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr_q[PtrW-1:0]] <= wdata;
  end

endmodule

// File: rtl/inst_fetcher.sv
// Byte-wide instruction fetch: assembles little-endian words, queues them and
// feeds the decoder one per cycle; a jump flushes everything in flight.
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter int unsigned             QUEUE_DEPTH = 4,
  parameter logic [InstAddrBus-1:0]  RESET_PC    = ResetPcDefault
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    memGrant,
  input  logic                    memDinValid,
  input  logic [ByteBus-1:0]      memDin,
  output logic                    memRe,
  output logic [InstAddrBus-1:0]  memAddr,
  input  logic                    stall,
  input  logic                    jumpEn,
  input  logic [InstAddrBus-1:0]  jumpAddr,
  output logic                    DecEn,
  output logic [InstAddrBus-1:0]  instPC,
  output logic [InstBus-1:0]      inst
);

  localparam int unsigned CntW = $clog2(QUEUE_DEPTH) + 1;

  fetch_state_e            state_q, state_d;
  logic [1:0]              byte_cnt_q, byte_cnt_d;
  logic [InstAddrBus-1:0]  fetch_pc_q, fetch_pc_d;
  logic [InstBus-1:0]      asm_buf_q, asm_buf_d;
  logic                    drop_next_q, drop_next_d;
  logic                    req_q;
  logic [1:0]              req_idx_q;

  logic                    accept, rx_ok, push, pop, slot_free;
  logic                    q_full, q_empty;
  logic [CntW-1:0]         q_count;
  logic [InstAddrBus+InstBus-1:0] q_wdata, q_rdata;

  assign memRe   = (state_q == StFetch) && !jumpEn;
  assign memAddr = memRe ? (fetch_pc_q + {30'b0, byte_cnt_q}) : '0;
  assign accept  = memRe && memGrant;

  // Only a byte answering last cycle's accepted request is taken.
  assign rx_ok   = memDinValid && req_q && !drop_next_q && !jumpEn;
  assign push    = rx_ok && (req_idx_q == 2'd3);
  assign pop     = !stall && !q_empty && !jumpEn;
  assign q_wdata = {fetch_pc_q, memDin, asm_buf_q[23:0]};

  // Will the queue have a free slot after this edge's push/pop?
  always_comb begin
    if (push == pop)  slot_free = !q_full;
    else if (pop)     slot_free = 1'b1;
    else              slot_free = (q_count < CntW'(QUEUE_DEPTH - 1));
  end

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    fetch_pc_d  = fetch_pc_q;
    asm_buf_d   = asm_buf_q;
    drop_next_d = drop_next_q;
    if (memDinValid && drop_next_q) drop_next_d = Disable;
    if (rx_ok) begin
      asm_buf_d[{req_idx_q, 3'b000} +: 8] = memDin;
      if (req_idx_q == 2'd3) fetch_pc_d = fetch_pc_q + 32'd4;
    end
    unique case (state_q)
      StFetch: begin
        if (accept) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) state_d = StHold;
        end
      end
      StHold: begin
        if (!(req_q && !memDinValid) && slot_free) state_d = StFetch;
      end
      default: state_d = StHold;
    endcase
    if (jumpEn) begin
      state_d     = StFetch;
      byte_cnt_d  = 2'd0;
      fetch_pc_d  = jumpAddr;
      // A request still unanswered in the jump cycle must be discarded later.
      drop_next_d = req_q && !memDinValid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StHold;
      byte_cnt_q  <= 2'd0;
      fetch_pc_q  <= RESET_PC;
      asm_buf_q   <= '0;
      drop_next_q <= Disable;
      req_q       <= Disable;
      req_idx_q   <= 2'd0;
      DecEn       <= Disable;
      instPC      <= '0;
      inst        <= '0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      fetch_pc_q  <= fetch_pc_d;
      asm_buf_q   <= asm_buf_d;
      drop_next_q <= drop_next_d;
      req_q       <= accept;
      req_idx_q   <= byte_cnt_q;
      DecEn       <= pop;
      if (pop) begin
        instPC <= q_rdata[InstAddrBus+InstBus-1:InstBus];
        inst   <= q_rdata[InstBus-1:0];
      end
    end
  end

  inst_queue #(
    .Depth (QUEUE_DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (jumpEn),
    .wdata (q_wdata),
    .rdata (q_rdata),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed bench for inst_fetcher with a fixed one-cycle-latency byte memory.
module tb_inst_fetcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        memGrant, memDinValid, memRe, stall, jumpEn, DecEn;
  logic [7:0]  memDin;
  logic [31:0] memAddr, jumpAddr, instPC, inst;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  inst_fetcher dut (
    .clk         (clk),
    .rst         (rst),
    .memGrant    (memGrant),
    .memDinValid (memDinValid),
    .memDin      (memDin),
    .memRe       (memRe),
    .memAddr     (memAddr),
    .stall       (stall),
    .jumpEn      (jumpEn),
    .jumpAddr    (jumpAddr),
    .DecEn       (DecEn),
    .instPC      (instPC),
    .inst        (inst)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a == 32'h0) return 32'h00A00093;
    return {~a[15:0], a[15:0]} ^ 32'h0000_0013;
  endfunction

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    logic [31:0] w;
    w = word_at({a[31:2], 2'b00});
    return w[{a[1:0], 3'b000} +: 8];
  endfunction

  // Memory answers every accepted request exactly one cycle later.
  always @(posedge clk) begin
    memDinValid <= memRe && memGrant;
    memDin      <= byte_at(memAddr);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_jump(input logic [31:0] addr);
    @(negedge clk);
    jumpEn = 1'b1; jumpAddr = addr;
    @(negedge clk);
    jumpEn = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; memGrant = 1'b1; stall = 1'b0; jumpEn = 1'b0; jumpAddr = '0;
    memDinValid = 1'b0; memDin = '0;
    repeat (3) tick();
    n_checks++; if (memRe !== 1'b0) begin n_fail++; $display("FAIL reset_memRe got %0b want 0", memRe); end
    n_checks++; if (memAddr !== 32'h0) begin n_fail++; $display("FAIL reset_memAddr got %h want 0", memAddr); end
    n_checks++; if (DecEn !== 1'b0) begin n_fail++; $display("FAIL reset_DecEn got %0b want 0", DecEn); end
    n_checks++; if (inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst got %h want 0", inst); end
    n_checks++; if (instPC !== 32'h0) begin n_fail++; $display("FAIL reset_instPC got %h want 0", instPC); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_first_word();
    for (int i = 0; i < 10 && !memRe; i++) tick();
    n_checks++; if (memRe !== 1'b1 || memAddr !== 32'h0) begin
      n_fail++; $display("FAIL first_addr0 got re=%0b addr=%h want re=1 addr=0", memRe, memAddr); end
    for (int k = 1; k < 4; k++) begin
      tick();
      n_checks++; if (memRe !== 1'b1 || memAddr !== 32'(k)) begin
        n_fail++; $display("FAIL first_addr%0d got re=%0b addr=%h want re=1 addr=%0d", k, memRe, memAddr, k); end
    end
    tick();
    n_checks++; if (memRe !== 1'b0 || memDinValid !== 1'b1) begin
      n_fail++; $display("FAIL first_hold got re=%0b dv=%0b want re=0 dv=1", memRe, memDinValid); end
    tick();
    n_checks++; if (DecEn !== 1'b0) begin n_fail++; $display("FAIL first_nobypass got DecEn=%0b want 0", DecEn); end
    tick();
    n_checks++; if (DecEn !== 1'b1 || inst !== 32'h00A00093 || instPC !== 32'h0) begin
      n_fail++; $display("FAIL first_dec got en=%0b inst=%h pc=%h want en=1 inst=00a00093 pc=0", DecEn, inst, instPC); end
  endtask

  task automatic test_grant_low();
    logic [31:0] a;
    for (int i = 0; i < 20 && !(memRe && memAddr[1:0] == 2'd2); i++) tick();
    n_checks++; if (!(memRe && memAddr[1:0] == 2'd2)) begin
      n_fail++; $display("FAIL grant_find got re=%0b addr=%h want byte2 request", memRe, memAddr); end
    a = memAddr;
    memGrant = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (memRe !== 1'b1 || memAddr !== a) begin
        n_fail++; $display("FAIL grant_hold%0d got re=%0b addr=%h want re=1 addr=%h", i, memRe, memAddr, a); end
    end
    memGrant = 1'b1;
    for (int i = 0; i < 30 && !DecEn; i++) tick();
    n_checks++; if (DecEn !== 1'b1 || instPC !== a - 32'd2 || inst !== word_at(a - 32'd2)) begin
      n_fail++; $display("FAIL grant_word got en=%0b pc=%h inst=%h want en=1 pc=%h inst=%h",
                         DecEn, instPC, inst, a - 32'd2, word_at(a - 32'd2)); end
  endtask

  task automatic test_stall_full();
    int accepts = 0;
    int decs = 0;
    logic [31:0] first_addr;
    logic seen_re;
    stall = 1'b1;
    do_jump(32'h0);
    for (int i = 0; i < 60; i++) begin
      if (memRe && memGrant) accepts++;
      if (DecEn) decs++;
      tick();
    end
    n_checks++; if (accepts != 16) begin n_fail++; $display("FAIL stall_accepts got %0d want 16", accepts); end
    n_checks++; if (decs != 0) begin n_fail++; $display("FAIL stall_decen got %0d want 0", decs); end
    n_checks++; if (memRe !== 1'b0) begin n_fail++; $display("FAIL stall_memRe got %0b want 0", memRe); end
    stall = 1'b0;
    seen_re = 1'b0; first_addr = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (memRe && !seen_re) begin seen_re = 1'b1; first_addr = memAddr; end
      n_checks++; if (DecEn !== 1'b1 || instPC !== 32'(4 * k) || inst !== word_at(32'(4 * k))) begin
        n_fail++; $display("FAIL stall_drain%0d got en=%0b pc=%h inst=%h want en=1 pc=%h", k, DecEn, instPC, inst, 4 * k); end
    end
    tick();
    n_checks++; if (DecEn !== 1'b0) begin n_fail++; $display("FAIL stall_gap got DecEn=%0b want 0", DecEn); end
    n_checks++; if (!seen_re || first_addr !== 32'h10) begin
      n_fail++; $display("FAIL stall_resume got seen=%0b addr=%h want addr=10", seen_re, first_addr); end
  endtask

  task automatic test_jump();
    do_jump(32'h0);
    for (int i = 0; i < 40 && !(memRe && memAddr == 32'h9); i++) tick();
    n_checks++; if (!(memRe && memAddr == 32'h9)) begin
      n_fail++; $display("FAIL jump_find got re=%0b addr=%h want addr=9", memRe, memAddr); end
    @(negedge clk);
    jumpEn = 1'b1; jumpAddr = 32'h100;
    #1;
    n_checks++; if (memRe !== 1'b0 || memDinValid !== 1'b1) begin
      n_fail++; $display("FAIL jump_cycle got re=%0b dv=%0b want re=0 dv=1", memRe, memDinValid); end
    @(negedge clk);
    jumpEn = 1'b0;
    #1;
    n_checks++; if (DecEn !== 1'b0 || memRe !== 1'b1 || memAddr !== 32'h100) begin
      n_fail++; $display("FAIL jump_after got en=%0b re=%0b addr=%h want en=0 re=1 addr=100", DecEn, memRe, memAddr); end
    for (int i = 0; i < 30 && !DecEn; i++) tick();
    n_checks++; if (DecEn !== 1'b1 || instPC !== 32'h100 || inst !== word_at(32'h100)) begin
      n_fail++; $display("FAIL jump_word got en=%0b pc=%h inst=%h want en=1 pc=100 inst=%h", DecEn, instPC, inst, word_at(32'h100)); end
  endtask

  task automatic test_jump_byte3();
    stall = 1'b1;
    do_jump(32'h200);
    for (int i = 0; i < 40 && !(memRe && memAddr == 32'h207); i++) tick();
    n_checks++; if (!(memRe && memAddr == 32'h207)) begin
      n_fail++; $display("FAIL jb3_find got re=%0b addr=%h want addr=207", memRe, memAddr); end
    @(negedge clk);
    stall = 1'b0; jumpEn = 1'b1; jumpAddr = 32'h300;
    #1;
    n_checks++; if (memDinValid !== 1'b1 || DecEn !== 1'b0) begin
      n_fail++; $display("FAIL jb3_cycle got dv=%0b en=%0b want dv=1 en=0", memDinValid, DecEn); end
    @(negedge clk);
    jumpEn = 1'b0;
    #1;
    n_checks++; if (DecEn !== 1'b0 || memAddr !== 32'h300) begin
      n_fail++; $display("FAIL jb3_after got en=%0b addr=%h want en=0 addr=300", DecEn, memAddr); end
    for (int i = 0; i < 30 && !DecEn; i++) tick();
    n_checks++; if (DecEn !== 1'b1 || instPC !== 32'h300 || inst !== word_at(32'h300)) begin
      n_fail++; $display("FAIL jb3_word got en=%0b pc=%h inst=%h want en=1 pc=300", DecEn, instPC, inst); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 40 && !(DecEn && memRe); i++) tick();
    n_checks++; if (!(DecEn && memRe)) begin
      n_fail++; $display("FAIL rmid_find got en=%0b re=%0b want both 1", DecEn, memRe); end
    rst = 1'b1;
    #1;
    n_checks++; if (memRe !== 1'b0 || DecEn !== 1'b0) begin
      n_fail++; $display("FAIL rmid_async got re=%0b en=%0b want 0 0", memRe, DecEn); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 10 && !memRe; i++) tick();
    n_checks++; if (memRe !== 1'b1 || memAddr !== 32'h0) begin
      n_fail++; $display("FAIL rmid_restart got re=%0b addr=%h want re=1 addr=0", memRe, memAddr); end
    tick();
    n_checks++; if (memAddr !== 32'h1) begin n_fail++; $display("FAIL rmid_addr1 got %h want 1", memAddr); end
    for (int i = 0; i < 30 && !DecEn; i++) tick();
    n_checks++; if (DecEn !== 1'b1 || instPC !== 32'h0 || inst !== 32'h00A00093) begin
      n_fail++; $display("FAIL rmid_word got en=%0b pc=%h inst=%h want en=1 pc=0 inst=00a00093", DecEn, instPC, inst); end
  endtask

  initial begin
    test_reset();
    test_first_word();
    test_grant_low();
    test_stall_full();
    test_jump();
    test_jump_byte3();
    test_reset_mid();
    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetcher.md
Name: inst_fetcher

Overview:
Front-end instruction fetch unit that produces the `DecEn`/`instPC`/`inst` stream consumed by the decoder.
- Issues byte-wide reads to the memory controller and assembles four little-endian bytes into 32-bit instructions.
- Buffers assembled instructions in a small queue and presents one instruction per cycle to the decoder, subject to dispatcher stall.
- Handles redirects (jump/branch mispredict) by flushing the queue and all in-flight fetch state.

Parameters:
QUEUE_DEPTH, 4, number of assembled instructions buffered (power of two, ≥2)
RESET_PC, 32'h0, fetch address after reset

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
memGrant  in  1  memory controller accepts the request presented this cycle
memDinValid  in  1  memDin holds the byte for the request accepted the previous cycle
memDin  in  8  returned byte
memRe  out  1  byte read request
memAddr  out  32  byte address of request
stall  in  1  dispatcher cannot accept an instruction this cycle
jumpEn  in  1  redirect fetch
jumpAddr  in  32  redirect target
DecEn  out  1  inst/instPC valid for the decoder
instPC  out  32  address of inst
inst  out  32  instruction word

Behaviour:
- Reset (async, rst=1): queue empty, byteCnt=0, fetchPC=RESET_PC, asmBuf=0, dropNext=0, memRe=0, memAddr=0, DecEn=0, inst=0, instPC=0.
- Issue state machine: states FETCH and HOLD.
  - FETCH: memRe=1, memAddr=fetchPC+byteCnt (combinational from registers).
  - Request accepted iff memRe&memGrant; then byteCnt increments (mod 4).
  - Not granted: memAddr is held unchanged.
  - After the 4th byte is accepted, move to HOLD until that byte returns.
  - HOLD: memRe=0. On return of the 4th byte, enter FETCH only if the queue will have a free slot; otherwise stay in HOLD.
  - Free-slot rule: issue of a new word's byte 0 is allowed only if count + (word in flight ? 1 : 0) < QUEUE_DEPTH.
- Data return: exactly one cycle after acceptance, memDinValid=1. Byte k is written to asmBuf[8k+7:8k].
  - On byte 3 arrival: push {fetchPC, assembled word} into the queue, then fetchPC += 4 (wraps mod 2^32).
- Output stage (registered, one cycle):
  - Each cycle, if !stall and the queue is non-empty, pop the head. Next cycle DecEn=1, inst/instPC = popped entry.
  - Otherwise next cycle DecEn=0; inst/instPC hold their last values.
  - No bypass: a word pushed at edge t can drive DecEn at the earliest after edge t+1.
- Push and pop in the same cycle are both allowed, including when the queue is full or empty.
- Redirect (jumpEn=1), highest priority:
  - At the edge: flush the queue, fetchPC=jumpAddr, byteCnt=0, state=FETCH, DecEn=0 next cycle.
  - A pop requested in the same cycle is cancelled.
  - If a request was accepted in the jump cycle or the cycle before, set dropNext. The byte returning under dropNext is discarded and clears dropNext.
  - memRe is forced to 0 during the jump cycle, so a grant that cycle is meaningless.
  - jumpAddr[1:0] is used as-is; no alignment check.
- memDinValid without an outstanding request: ignored. A bench assertion flags it.
- Simultaneous jumpEn and the 4th byte arriving: the byte is dropped and no push occurs.
- Reset mid-operation: all state returns to reset values immediately; a returning byte is ignored.

Decomposition:
- Shared defines header: InstAddrBus, InstBus, Enable/Disable, byte bus width, RESET_PC default.
- One sub-module, inst_queue: synchronous FIFO with entry {pc[31:0], inst[31:0]}.
  - Ports: push, pop, flush, full, empty, count.
  - Pointer wrap-around handled with an extra MSB bit.
  - flush has priority over push and pop.
- Top level holds the issue FSM, byte assembly and the output register.

Test Plan:
- Release reset; memGrant=1 always; memory returns bytes 93,00,A0,00 at addresses 0..3 → memAddr 0,1,2,3 on consecutive cycles; DecEn=1 with inst=32'h00A00093, instPC=0 two cycles after byte 3 returns.
- memGrant low for 3 cycles during byte 2 → memAddr stays at 2, memRe stays 1; assembled word unchanged; PC sequence unaffected.
- stall=1 continuously with QUEUE_DEPTH=4 → exactly 4 words pushed, then memRe=0 with no further requests; release stall → DecEn=1 for 4 consecutive cycles with instPC 0,4,8,C, after which fetch resumes at 0x10.
- jumpEn with jumpAddr=32'h100 while byte 1 of the word at 0x8 is in flight → returned byte dropped; queue empty; DecEn=0 next cycle; next memAddr=0x100; first decoded instPC=0x100.
- jumpEn in the same cycle as byte 3 returns and a pop is pending → no push, no DecEn, fetch restarts at jumpAddr.
- Assert rst mid-word for 1 cycle → memRe and DecEn drop asynchronously; after release, fetch restarts at RESET_PC with byteCnt=0.
